// File: rtl/btn_updown_cnt.sv
// Two-button up/down event counter: each raw button is synchronized, debounced
// and edge-detected; accepted presses step a counter that drives the LEDs.
module btn_updown_cnt #(
  parameter int          DB_CYCLES = 1000000,
  parameter int          CNT_W     = 8,
  parameter logic [31:0] CNT_INIT  = 32'h0000_00AA
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             btn_inc,
  input  logic             btn_dec,
  output logic             inc_pulse,
  output logic             dec_pulse,
  output logic             inc_level,
  output logic             dec_level,
  output logic [CNT_W-1:0] count,
  output logic [CNT_W-1:0] led
);

  localparam int             DBW    = $clog2(DB_CYCLES);
  localparam logic [DBW-1:0] DB_MAX = DBW'(DB_CYCLES - 1);

  // Index 0 is the increment button, index 1 the decrement button.
  logic [1:0]     w_btn;
  logic [1:0]     r_s1;
  logic [1:0]     r_s2;
  logic [1:0]     r_pre1;
  logic [1:0]     r_pre2;
  logic [1:0]     r_level;
  logic [1:0]     r_pulse;
  logic [1:0]     r_blk;
  logic [1:0]     w_accept;
  logic [1:0]     w_rise;
  logic [DBW-1:0] r_db_cnt [2];
  logic [CNT_W-1:0] r_count;

  assign w_btn = {btn_dec, btn_inc};

  always_comb begin
    w_accept = '0;
    w_rise   = '0;
    for (int i = 0; i < 2; i++) begin
      w_accept[i] = (r_s2[i] != r_level[i]) && (r_db_cnt[i] == DB_MAX);
      w_rise[i]   = w_accept[i] && r_s2[i];
    end
  end

  // Free-running synchronizer, kept alive through reset so we know whether a
  // button was already held when reset was applied.
  always_ff @(posedge clk) begin
    r_pre1 <= w_btn;
    r_pre2 <= r_pre1;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_s1     <= '0;
      r_s2     <= '0;
      r_level  <= '0;
      r_pulse  <= '0;
      r_blk    <= r_pre2;
      for (int i = 0; i < 2; i++) r_db_cnt[i] <= '0;
    end else begin
      r_s1  <= w_btn;
      r_s2  <= r_s1;
      // A press held through reset stays blocked until the button is let go.
      r_blk <= r_blk & r_pre2;
      for (int i = 0; i < 2; i++) begin
        r_pulse[i] <= w_rise[i] && !r_blk[i];
        if (r_s2[i] == r_level[i]) begin
          r_db_cnt[i] <= '0;
        end else if (r_db_cnt[i] == DB_MAX) begin
          r_level[i]  <= r_s2[i];
          r_db_cnt[i] <= '0;
        end else begin
          r_db_cnt[i] <= r_db_cnt[i] + DBW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_count <= CNT_INIT[CNT_W-1:0];
    end else begin
      case (r_pulse)
        2'b01:   r_count <= r_count + CNT_W'(1);
        2'b10:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign inc_pulse = r_pulse[0];
  assign dec_pulse = r_pulse[1];
  assign inc_level = r_level[0];
  assign dec_level = r_level[1];
  assign count     = r_count;
  assign led       = r_count;

endmodule

// File: doc/btn_updown_cnt.md
Name: btn_updown_cnt

Overview:
- Input-side counterpart to the board's LED counter displays. Takes two raw push-buttons (increment, decrement) from the FPGA board.
- Synchronizes and debounces each button, then detects the press edges.
- Drives an up/down event counter whose value goes straight to the LEDs.
- Sits between the board button pins and the LED pins, in the PLL output clock domain.

Parameters:
- DB_CYCLES, 1000000, number of consecutive stable cycles required to accept a button level change (10 ms at 100 MHz); legal range ≥ 2.
- CNT_W, 8, width of the event counter and of the led output.
- CNT_INIT, 8'hAA, counter value loaded on reset; only the low CNT_W bits are used.

Ports:
- clk  input  1  system clock; all logic is on its rising edge.
- rst  input  1  synchronous, active-low reset; the design is reset while rst is 0 at a clk edge.
- btn_inc  input  1  raw, asynchronous, bouncing increment button; 1 = pressed.
- btn_dec  input  1  raw, asynchronous, bouncing decrement button; 1 = pressed.
- inc_pulse  output  1  one-cycle strobe on an accepted increment press.
- dec_pulse  output  1  one-cycle strobe on an accepted decrement press.
- inc_level  output  1  debounced level of btn_inc.
- dec_level  output  1  debounced level of btn_dec.
- count  output  CNT_W  current counter value.
- led  output  CNT_W  equal to count; wired to the board LEDs.

Behaviour:
- Reset (rst=0 at an edge) sets:
  - both synchronizer flip-flops to 0;
  - both debounce counters to 0;
  - inc_level and dec_level to 0;
  - inc_pulse and dec_pulse to 0;
  - count to CNT_INIT[CNT_W-1:0].
- Reset mid-debounce discards the partial count. No pulse is produced for a button held through reset release unless it is released and pressed again; a held button still becomes inc_level=1 after debounce, but it yields no pulse.
- Synchronizer: two flip-flops per button (s1, then s2). Only s2 feeds the debounce logic.
- Debounce, per button, independent between the two buttons. The counter width is clog2(DB_CYCLES).
  - If s2 equals the level, the counter is set to 0.
  - Else, if the counter equals DB_CYCLES-1, the level takes s2 and the counter is set to 0.
  - Else, the counter increments.
- Latency: if the raw input changes before edge 1 and stays stable, s2 updates at edge 2 and the level changes at edge DB_CYCLES+2.
- Glitch filtering: any s2 excursion shorter than DB_CYCLES cycles never changes the level.
- Release is debounced the same way as press.
- Pulse generation: the pulse is registered high at the same edge where the level goes 0→1, and is low at all other edges. Its width is exactly 1 cycle. A level change 1→0 produces no pulse.
- Counter update, at the edge after the pulse is high (edge DB_CYCLES+3 in the latency example):
  - inc_pulse=1, dec_pulse=0: count+1, wrapping 2^CNT_W-1 → 0.
  - dec_pulse=1, inc_pulse=0: count-1, wrapping 0 → 2^CNT_W-1.
  - both pulses 1 in the same cycle: count unchanged.
  - neither pulse: count unchanged.
- Holding a button never repeats: one press gives one pulse.
- led is a continuous assignment of count, with no extra register.
- No combinational path exists from any input to any output.

Test Plan:
1. Reset, DB_CYCLES=4 → during rst=0 and after release: count=led=8'hAA, both pulses 0, both levels 0.
2. btn_inc stepped to 1 before edge 1 and held → inc_level=1 and inc_pulse=1 after edge 6 only; count=8'hAB after edge 7; holding 100 more cycles gives no further change.
3. btn_inc toggled 1 for 3 cycles then 0 (bounce shorter than DB_CYCLES=4) → inc_level stays 0, no pulse, count stays 8'hAA. Next, a 4-cycle-stable press → accepted.
4. Wrap-around:
   - CNT_INIT=8'hFF, one accepted inc press → count=8'h00.
   - From 8'h00, one dec press → count=8'hFF.
5. btn_inc and btn_dec raised at the same edge and held → both pulses high in the same cycle, count unchanged at 8'hAA. Then releasing both and pressing dec alone → 8'hA9.
6. btn_dec held until its debounce counter reaches 2 (DB_CYCLES=4), then rst=0 for 1 cycle with btn_dec still held → count=8'hAA, the debounce restarts, dec_level rises after a full DB_CYCLES+2 edges from reset release with dec_pulse staying 0 and count unchanged, and a later release-and-press yields exactly one decrement.
